// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: widths, coin denominations and
// the dispenser state encoding.
package vending_machine_def;

    localparam int kNumCoins  = 3;
    localparam int kTotalBits = 31;
    localparam int kCoinVal0  = 100;
    localparam int kCoinVal1  = 500;
    localparam int kCoinVal2  = 1000;
    localparam int kCountBits = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } disp_state_e;

    function automatic logic [kTotalBits-1:0] coin_value(input int idx);
        case (idx)
            0:       coin_value = kTotalBits'(kCoinVal0);
            1:       coin_value = kTotalBits'(kCoinVal1);
            default: coin_value = kTotalBits'(kCoinVal2);
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: largest available coin whose value fits in the
// remaining balance.
module coin_select
    import vending_machine_def::*;
(
    input  logic [kTotalBits-1:0] i_remain,
    input  logic [kNumCoins-1:0]  i_avail,
    output logic [kNumCoins-1:0]  o_coin,
    output logic [kTotalBits-1:0] o_value,
    output logic                  o_found
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_coin  = '0;
        o_value = '0;
        o_found = 1'b0;
        for (int k = kNumCoins - 1; k >= 0; k--) begin
            if (!o_found && i_avail[k] && (i_remain >= coin_value(k))) begin
                o_coin[k] = 1'b1;
                o_value   = coin_value(k);
                o_found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Converts a returned balance into greedy single-coin hopper transactions.
// Optional per-denomination stock tracking is enabled by CHANGE_INVENTORY_EN.
module change_dispenser
    import vending_machine_def::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [kTotalBits-1:0] i_amount,
    input  logic                  i_coin_ready,
`ifdef CHANGE_INVENTORY_EN
    input  logic                  i_refill,
    input  logic [kNumCoins-1:0]  i_refill_coin,
    output logic [kNumCoins-1:0]  o_stock_empty,
`endif
    output logic [kNumCoins-1:0]  o_coin,
    output logic                  o_coin_valid,
    output logic                  o_busy,
    output logic [kTotalBits-1:0] o_remain,
    output logic [kCountBits-1:0] o_coin_count,
    output logic [kTotalBits-1:0] o_residue,
    output logic                  o_done
);

    disp_state_e           r_state;
    disp_state_e           w_next;
    logic [kTotalBits-1:0] r_remain;
    logic [kTotalBits-1:0] r_residue;
    logic [kTotalBits-1:0] r_coin_value;
    logic [kNumCoins-1:0]  r_coin;
    logic [kCountBits-1:0] r_count;
    logic [kNumCoins-1:0]  w_avail;
    logic [kNumCoins-1:0]  w_sel_coin;
    logic [kTotalBits-1:0] w_sel_value;
    logic                  w_found;
    logic                  w_handshake;

    assign w_handshake = (r_state == DISPENSE) && i_coin_ready;

`ifdef CHANGE_INVENTORY_EN
    logic [kNumCoins-1:0][kCountBits-1:0] r_stock;

    // A refill and a dispense of the same denomination cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stock <= '0;
        end else begin
            for (int k = 0; k < kNumCoins; k++) begin
                case ({i_refill && i_refill_coin[k], w_handshake && r_coin[k]})
                    2'b10: if (r_stock[k] != {kCountBits{1'b1}}) r_stock[k] <= r_stock[k] + 1'b1;
                    2'b01: r_stock[k] <= r_stock[k] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < kNumCoins; k++) w_avail[k] = (r_stock[k] != '0);
    end
    assign o_stock_empty = ~w_avail;
`else
    assign w_avail = '1;
`endif

    coin_select u_coin_select (
        .i_remain (r_remain),
        .i_avail  (w_avail),
        .o_coin   (w_sel_coin),
        .o_value  (w_sel_value),
        .o_found  (w_found)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_start) w_next = SELECT;
            SELECT:   w_next = w_found ? DISPENSE : DONE;
            DISPENSE: if (i_coin_ready) w_next = SELECT;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remain     <= '0;
            r_residue    <= '0;
            r_coin       <= '0;
            r_coin_value <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_remain  <= i_amount;
                    r_count   <= '0;
                    r_residue <= '0;
                end
                SELECT: if (w_found) begin
                    r_coin       <= w_sel_coin;
                    r_coin_value <= w_sel_value;
                end else begin
                    r_residue <= r_remain;
                end
                DISPENSE: if (w_handshake) begin
                    r_remain <= r_remain - r_coin_value;
                    r_coin   <= '0;
                    if (r_count != {kCountBits{1'b1}}) r_count <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_coin       = r_coin;
    assign o_coin_valid = (r_state == DISPENSE);
    assign o_busy       = (r_state != IDLE);
    assign o_remain     = r_remain;
    assign o_coin_count = r_count;
    assign o_residue    = r_residue;
    assign o_done       = (r_state == DONE);

endmodule
